// File: rtl/parking_sensor_gen.sv
// Parking-lot barrier sensor stimulus generator.
// Drives the outer (a) and inner (b) sensor lines with ordered crossing sequences:
// entry, exit, and balked passes. It keeps its own occupancy model so the traffic it
// produces never overfills or underflows the lot.
module parking_sensor_gen #(
  parameter int unsigned DWELL   = 4,  // cycles each non-idle pattern is held (>= 1)
  parameter int unsigned GAP     = 2,  // cycles of ab=00 after a sequence (>= 1)
  parameter int unsigned MAX_OCC = 7   // full threshold of the occupancy model (<= 7)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       reject,
  output logic [2:0] occ
);

  localparam int unsigned MaxLen = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned TimerW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  localparam logic [TimerW-1:0] DwellLast = TimerW'(DWELL - 1);
  localparam logic [TimerW-1:0] GapLast   = TimerW'(GAP - 1);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
  localparam logic [2:0]        OccFull   = 3'(MAX_OCC);

  // mode[0] selects the exit direction; mode[1] marks a balked pass.
  localparam logic [1:0] ModeEntry = 2'b00;
  localparam logic [1:0] ModeExit  = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StPh1,
    StPh2,
    StPh3,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        mode_q, mode_d;
  logic              abort_flag_q, abort_flag_d;
  logic [2:0]        occ_q, occ_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              reject_q, reject_d;

  logic refuse;
  logic phase_last;
  logic gap_last;

  assign refuse     = ((mode == ModeEntry) && (occ_q == OccFull)) ||
                      ((mode == ModeExit) && (occ_q == 3'd0));
  assign phase_last = (timer_q == DwellLast);
  assign gap_last   = (timer_q == GapLast);

  // Sequencer: start acceptance/refusal, phase timing, abort and occupancy update.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mode_d       = mode_q;
    abort_flag_d = abort_flag_q;
    occ_d        = occ_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    reject_d     = 1'b0;

    case (state_q)
      StIdle: begin
        // abort is meaningless here, so a simultaneous start simply wins
        if (start) begin
          if (refuse) begin
            reject_d = 1'b1;
          end else begin
            state_d      = StPh1;
            mode_d       = mode;
            timer_d      = '0;
            abort_flag_d = 1'b0;
          end
        end
      end
      StPh1, StPh2, StPh3: begin
        if (abort) begin
          state_d      = StGap;
          timer_d      = '0;
          abort_flag_d = 1'b1;
        end else if (phase_last) begin
          timer_d = '0;
          case (state_q)
            StPh1:   state_d = StPh2;
            StPh2:   state_d = StPh3;
            default: state_d = StGap;
          endcase
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StGap: begin
        if (gap_last) begin
          state_d   = StIdle;
          timer_d   = '0;
          done_d    = 1'b1;
          aborted_d = abort_flag_q;
          // Only completed, non-balked passes move a vehicle across the barrier.
          if (!abort_flag_q && !mode_q[1]) begin
            occ_d = mode_q[0] ? (occ_q - 3'd1) : (occ_q + 3'd1);
          end
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // Sensor pattern for the upcoming state, so a/b change on the same edge as the state.
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    busy_d = (state_d != StIdle);
    case (state_d)
      StPh1: begin
        a_d = ~mode_d[0];
        b_d = mode_d[0];
      end
      StPh2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      StPh3: begin
        // A balk backs out the way it came; a full pass releases the far sensor last.
        a_d = mode_d[1] ? ~mode_d[0] : mode_d[0];
        b_d = mode_d[1] ? mode_d[0] : ~mode_d[0];
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      mode_q       <= 2'b00;
      abort_flag_q <= 1'b0;
      occ_q        <= 3'd0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mode_q       <= mode_d;
      abort_flag_q <= abort_flag_d;
      occ_q        <= occ_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      reject_q     <= reject_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign reject  = reject_q;
  assign occ     = occ_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench for parking_sensor_gen with DWELL=2, GAP=3, MAX_OCC=7.
module tb_parking_sensor_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       abort = 1'b0;
  logic       a, b, busy, done, aborted, reject;
  logic [2:0] occ;

  int n_checks = 0;
  int n_pass   = 0;

  parking_sensor_gen #(
    .DWELL  (2),
    .GAP    (3),
    .MAX_OCC(7)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .aborted(aborted),
    .reject (reject),
    .occ    (occ)
  );

  always #5 clk = ~clk;

  // Expected ab over the 9 busy cycles, first cycle in the top two bits.
  localparam logic [17:0] PatEntry     = 18'b10_10_11_11_01_01_00_00_00;
  localparam logic [17:0] PatExit      = 18'b01_01_11_11_10_10_00_00_00;
  localparam logic [17:0] PatEntryBalk = 18'b10_10_11_11_10_10_00_00_00;
  localparam logic [17:0] PatExitBalk  = 18'b01_01_11_11_01_01_00_00_00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Raise start for one cycle; returns at the sampling point of cycle 1.
  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full sequence; optional poke issues an exit start during PH1.
  task automatic run_seq(input string tag, input logic [1:0] m, input logic [17:0] pat,
                         input logic [2:0] exp_occ, input bit poke);
    logic [17:0] p;
    p = pat;
    do_start(m);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (poke && i == 0) begin
        start = 1'b1;
        mode  = 2'b01;
      end
      if (poke && i == 1) start = 1'b0;
      check($sformatf("%s ab[%0d]", tag, i), 32'({a, b}), 32'(p[17-2*i -: 2]));
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s done[%0d]", tag, i), 32'(done), 32'd0);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " aborted"}, 32'(aborted), 32'd0);
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " ab end"}, 32'({a, b}), 32'd0);
    check({tag, " occ"}, 32'(occ), 32'(exp_occ));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  task automatic expect_reject(input string tag, input logic [1:0] m, input logic [2:0] exp_occ);
    do_start(m);
    check({tag, " reject"}, 32'(reject), 32'd1);
    check({tag, " ab"}, 32'({a, b}), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " occ"}, 32'(occ), 32'(exp_occ));
    @(negedge clk);
    check({tag, " reject pulse"}, 32'(reject), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst ab", 32'({a, b}), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst reject", 32'(reject), 32'd0);
    check("rst occ", 32'(occ), 32'd0);
    reset = 1'b1;

    // Entry from reset, then fill to 7, overflow refusal, one exit
    run_seq("entry1", 2'b00, PatEntry, 3'd1, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      run_seq($sformatf("fill%0d", k), 2'b00, PatEntry, 3'(k), 1'b0);
    end
    expect_reject("overflow", 2'b00, 3'd7);
    run_seq("exit_full", 2'b01, PatExit, 3'd6, 1'b0);

    // Underflow refusal and balks from empty
    apply_reset();
    check("reset occ", 32'(occ), 32'd0);
    expect_reject("underflow", 2'b01, 3'd0);
    run_seq("entry_balk", 2'b10, PatEntryBalk, 3'd0, 1'b0);
    run_seq("exit_balk", 2'b11, PatExitBalk, 3'd0, 1'b0);

    // Abort during the second PH2 cycle
    do_start(2'b00);
    check("abort ph1", 32'({a, b}), 32'b10);
    @(negedge clk);
    @(negedge clk);
    check("abort ph2a", 32'({a, b}), 32'b11);
    @(negedge clk);
    check("abort ph2b", 32'({a, b}), 32'b11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ab", 32'({a, b}), 32'd0);
    check("abort busy", 32'(busy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort gap busy", 32'(busy), 32'd1);
      check("abort gap done", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("abort done", 32'(done), 32'd1);
    check("abort aborted", 32'(aborted), 32'd1);
    check("abort occ", 32'(occ), 32'd0);
    @(negedge clk);
    check("abort pulse", 32'(aborted), 32'd0);

    // Start while busy is ignored
    run_seq("busy_start", 2'b00, PatEntry, 3'd1, 1'b1);

    // Asynchronous reset in PH2
    do_start(2'b00);
    @(negedge clk);
    @(negedge clk);
    check("rstmid ph2", 32'({a, b}), 32'b11);
    #2 reset = 1'b0;
    #1;
    check("rstmid ab", 32'({a, b}), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid occ", 32'(occ), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("rstmid no done", 32'(dcnt), 32'd0);
    run_seq("after_rst", 2'b00, PatEntry, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_sensor_gen.md
Name: parking_sensor_gen

Overview:
- Drives the two parking-lot barrier sensor lines (a, b) with correctly ordered vehicle crossing sequences: entry, exit, and aborted "balk" passes.
- Used as the stimulus source in integration benches, and as the demo-board driver in place of physical sensors.
- Keeps its own 3-bit occupancy model so the generated traffic never drives the lot past full (7) or below empty (0).
- Sits upstream of the entry/exit detector FSMs and the 3-bit up/down occupancy counter.

Parameters:
- DWELL, 4: clock cycles each non-idle sensor pattern is held; must be >= 1.
- GAP, 2: cycles of ab=00 after a sequence before done; must be >= 1.
- MAX_OCC, 7: full threshold of the occupancy model; must be <= 7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a sequence; sampled only in IDLE.
- mode  input  2  00 entry, 01 exit, 10 entry-balk, 11 exit-balk; sampled with start.
- abort  input  1  cut the current sequence short.
- a  output  1  outer sensor line (registered).
- b  output  1  inner sensor line (registered).
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence end.
- aborted  output  1  one-cycle pulse, coincident with done, when the sequence was aborted.
- reject  output  1  one-cycle pulse when a start is refused.
- occ  output  3  modelled occupancy.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, a=b=0, busy=done=aborted=reject=0, occ=0, timer=0. Reset mid-sequence forces ab=00 immediately; no done pulse follows.
- States: IDLE, PH1, PH2, PH3, GAP. Each edge below is a rising clk edge.
- Patterns, written ab, for PH1/PH2/PH3:
  - entry: 10, 11, 01
  - exit: 01, 11, 10
  - entry-balk: 10, 11, 10
  - exit-balk: 01, 11, 01
  - IDLE and GAP drive 00.
- Start accepted: IDLE, start=1, and not refused.
  - At the same edge: latch mode, state goes to PH1, busy goes high, ab takes the PH1 pattern (visible the next cycle).
- Refusal: start in IDLE with mode=entry and occ==MAX_OCC, or mode=exit and occ==0.
  - reject pulses for 1 cycle; state stays IDLE; ab stays 00; occ unchanged.
  - Balk modes are never refused.
- Phase timing:
  - Each PHn lasts exactly DWELL cycles, then advances. PH3 goes to GAP.
  - GAP lasts GAP cycles, then goes to IDLE.
- End of sequence:
  - On the edge GAP goes to IDLE: busy=0, done=1 for one cycle, occ updated at that same edge.
  - occ update: entry +1, exit -1, balk unchanged.
- Latency: done is high in cycle 3*DWELL+GAP+1 after the accepting edge.
- abort=1 in PH1/PH2/PH3:
  - Next state is GAP; ab=00 from the next cycle.
  - Full GAP count runs, then done and aborted pulse together; occ unchanged.
  - abort in IDLE or GAP is ignored.
- start while busy: ignored, not queued.
- start and abort in the same IDLE cycle: abort is ignored and start is handled normally.
- occ never wraps; the refusal rule guarantees the range 0..MAX_OCC.
- a and b are never both changed in the same edge, except on reset or abort from PH2 (11 to 00); benches must tolerate that case.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (DWELL=2, GAP=3):
- Entry from reset: start, mode=00 -> ab = 10,10,11,11,01,01,00,00,00 over 9 cycles; done in cycle 10; occ=1; busy high for exactly 9 cycles.
- Fill and overflow: 7 entries -> occ=7; 8th entry start -> reject pulse, ab stays 00, occ=7, busy=0. Then exit -> ab = 01,01,11,11,10,10,00,00,00; occ=6.
- Underflow and balk: after reset, exit start -> reject, occ=0. Then entry-balk -> ab = 10,10,11,11,10,10,00,00,00; done with occ=0.
- Abort: entry started, abort asserted in the second PH2 cycle -> ab=00 the next cycle; 3 GAP cycles; done and aborted high together; occ unchanged.
- Start while busy: pulse start with mode=01 during an entry's PH1 -> ignored; the entry completes unchanged; occ +1 only.
- Async reset mid-PH2 -> ab=00, busy=0, occ=0 without waiting for a clk edge; no done after reset release; the next start proceeds normally.
